itch_msg_sequencer: RTL and testbench
=====================================

# itch_msg_sequencer

Front-end controller for the speculative ITCH parser. It frames the incoming ITCH 5.0 byte stream into messages using the type byte and fixed per-type lengths, and steers each message to exactly one field decoder (add order, cancel, delete, replace, execute) over a shared registered byte bus. It also detects unknown types and stalled messages, and counts completed messages. It sits between the byte source and the decoder bank; each decoder's `valid_in` is `valid_out & dec_sel[i]`.

## Interface
- `GAP_TIMEOUT`, 16: consecutive idle (`valid_in` low) cycles that abort an in-flight message or end a discard; legal range 2..255.
- `CNT_W`, 32: width of `msg_count`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous reset, active-low (asserted at 0).
- `byte_in` in 8: stream byte.
- `valid_in` in 1: `byte_in` is valid this cycle; there is no backpressure.
- `byte_out` out 8: registered copy of the accepted byte, shared by all decoders.
- `valid_out` out 1: `byte_out` is valid and belongs to the selected decoder.
- `dec_sel` out 5: one-hot decoder select. [0] `A`/0x41 (36 B), [1] `X`/0x58 (23 B), [2] `D`/0x44 (19 B), [3] `U`/0x55 (35 B), [4] `E`/0x45 (31 B).
- `msg_start` out 1: `byte_out` is a message type byte.
- `msg_end` out 1: `byte_out` is the last byte of the message.
- `byte_idx` out 6: index of `byte_out` within its message; 0 is the type byte.
- `unknown_type` out 1: one-cycle pulse when an unrecognised type byte is seen.
- `abort` out 1: one-cycle pulse when an in-flight message is dropped by timeout.
- `busy` out 1: state is not IDLE.
- `msg_count` out CNT_W: number of completed routed messages; wraps modulo 2^CNT_W.

## Operation
- **States:** IDLE, ROUTE, DISCARD. Internal registers:
  - `remaining`: 6 bits.
  - `gap_cnt`: 8 bits, saturating.
  - `cur_sel`: 5 bits.
- **IDLE:**
  - `valid_in` with a known type: load `cur_sel` from the type, set `remaining` = len−1, emit the byte with `msg_start`=1 and `byte_idx`=0, then go to ROUTE.
  - `valid_in` with an unknown type: pulse `unknown_type`, keep `dec_sel`=0, do not emit `valid_out`, go to DISCARD.
  - `valid_in` low: hold in IDLE.
- **ROUTE:**
  - Each `valid_in` byte is emitted with `byte_idx` incremented and `remaining` decremented, and `gap_cnt` is cleared.
  - When the byte with `remaining`=1 is accepted, it is emitted with `msg_end`=1. At the same time `msg_count` increments, `cur_sel` clears and the state returns to IDLE.
  - Each `valid_in`-low cycle increments `gap_cnt`. When `gap_cnt` reaches GAP_TIMEOUT: pulse `abort`, clear `cur_sel`, go to IDLE. No `msg_end` is emitted and `msg_count` is unchanged.
- **DISCARD:**
  - Bytes are dropped.
  - `gap_cnt` counts consecutive `valid_in`-low cycles and is cleared by any valid byte.
  - Reaching GAP_TIMEOUT returns the state to IDLE silently (no pulse).
- **Back-to-back messages:** the byte after a message's last byte is a type byte and is accepted with no bubble, because the decision is made in the same cycle the FSM returns to IDLE.
- **`dec_sel` hold:** `dec_sel` stays constant for the whole message, including stall cycles. It reads 0 in IDLE and DISCARD, except on the output cycle of a type byte, where it already shows the new select.
- **Unknown-type value:** any byte other than the five codes is unknown, including 0x00.
- **Reset:**
  - All outputs are 0 (`byte_out`=0x00, `dec_sel`=0, `msg_count`=0) and the state is IDLE.
  - Reset asserted mid-message drops the message without an `abort` pulse.
  - The first valid byte after reset is treated as a type byte.

## Timing
- Latency from `byte_in` to `byte_out` is exactly 1 cycle. `valid_out`, `dec_sel`, `msg_start`, `msg_end` and `byte_idx` are registered and aligned with `byte_out`.
- `unknown_type` and `abort` are registered and asserted the cycle after the triggering input cycle.
- `msg_count` shows the updated value in the same cycle `msg_end` is high.
- When `valid_out`=0, `byte_out` and `byte_idx` hold their last values; decoders must qualify them with `valid_out`.
- Abort timing: an abort needs GAP_TIMEOUT consecutive idle cycles. A valid byte on the cycle `gap_cnt` would reach the threshold is accepted normally and no abort occurs.
- A new message can start on the cycle immediately after an `abort` or DISCARD exit.
- Throughput is one byte per cycle, sustained.

## Test plan
- **Back-to-back messages:** send `A` (36 B) then `D` (19 B), `valid_in` continuously high.
  - `dec_sel`=00001 for 36 cycles, then 00100 for 19 cycles.
  - `msg_start` at idx 0 of each message; `msg_end` at idx 35 and idx 18.
  - `msg_count`=2.
- **Stalls:** send `X` (23 B) with 3-cycle `valid_in` gaps after bytes 5 and 12.
  - `dec_sel`=00010 is held through the gaps; `byte_idx` is contiguous 0..22.
  - One `msg_end`; no `abort`.
- **Timeout:** send `U`, 10 bytes, then `valid_in` low for 16 cycles, then `E` (31 B).
  - `abort` pulses once and `msg_count` is unchanged for `U`.
  - `E` routes with `dec_sel`=10000 and `msg_count`=1.
- **Unknown type:** send 0x5A followed by 20 junk bytes, 16 idle cycles, then `A`.
  - `unknown_type` pulses once; no `valid_out` for the junk bytes.
  - `A` routes correctly.
- **Reset mid-message:** assert `rst`=0 at byte 15 of `A`.
  - All outputs are 0 immediately, asynchronously; no `abort`.
  - After release, the next byte 0x44 starts a `D` message with `byte_idx`=0.
- **Counter wrap:** with `CNT_W`=4, send 17 `D` messages → `msg_count` ends at 1.

Source files
------------

// File: rtl/itch_msg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : itch_msg_sequencer_if
//  Purpose  : Bundles the byte-stream input and the routed decoder-bus
//             outputs of the ITCH message sequencer.
//  Ports    : (interface signals)
//             byte_in/valid_in         - incoming ITCH byte stream
//             byte_out/valid_out       - registered byte bus to decoders
//             dec_sel                  - one-hot decoder select
//             msg_start/msg_end        - message framing strobes
//             byte_idx                 - index of byte_out in its message
//             unknown_type/abort       - error pulses
//             busy/msg_count           - status
//  Modports : master (byte source / observer), slave (sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
interface itch_msg_sequencer_if #(
   parameter int CNT_W = 32
);
   logic [7:0]       byte_in;
   logic             valid_in;
   logic [7:0]       byte_out;
   logic             valid_out;
   logic [4:0]       dec_sel;
   logic             msg_start;
   logic             msg_end;
   logic [5:0]       byte_idx;
   logic             unknown_type;
   logic             abort;
   logic             busy;
   logic [CNT_W-1:0] msg_count;

   modport master (
      output byte_in, valid_in,
      input  byte_out, valid_out, dec_sel, msg_start, msg_end, byte_idx,
      input  unknown_type, abort, busy, msg_count
   );

   modport slave (
      input  byte_in, valid_in,
      output byte_out, valid_out, dec_sel, msg_start, msg_end, byte_idx,
      output unknown_type, abort, busy, msg_count
   );
endinterface
`default_nettype wire

// File: rtl/itch_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : itch_msg_sequencer
//  Purpose  : Frames an ITCH 5.0 byte stream into messages using the type
//             byte and fixed per-type lengths, and steers each message to one
//             of five field decoders over a shared registered byte bus.
//             Detects unknown types and stalled messages, counts completed
//             messages.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous reset, active-low
//             bus  - itch_msg_sequencer_if.slave (stream in, decoder bus out)
//  Params   : GAP_TIMEOUT - idle cycles that abort a message / end a discard
//             CNT_W       - width of msg_count
//  Revision : 1.0 - initial release
// ============================================================================
module itch_msg_sequencer #(
   parameter int GAP_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  wire logic              clk,
   input  wire logic              rst,
   itch_msg_sequencer_if.slave    bus
);

   localparam logic [7:0]       c_GAP      = 8'(GAP_TIMEOUT);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   localparam logic [7:0] c_TYPE_A = 8'h41;
   localparam logic [7:0] c_TYPE_X = 8'h58;
   localparam logic [7:0] c_TYPE_D = 8'h44;
   localparam logic [7:0] c_TYPE_U = 8'h55;
   localparam logic [7:0] c_TYPE_E = 8'h45;

   localparam logic [5:0] c_LEN_A  = 6'd36;
   localparam logic [5:0] c_LEN_X  = 6'd23;
   localparam logic [5:0] c_LEN_D  = 6'd19;
   localparam logic [5:0] c_LEN_U  = 6'd35;
   localparam logic [5:0] c_LEN_E  = 6'd31;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ROUTE   = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t           r_state;
   logic [5:0]       r_remaining;
   logic [7:0]       r_gap_cnt;
   logic [4:0]       r_cur_sel;

   logic [7:0]       r_byte_out;
   logic             r_valid_out;
   logic [4:0]       r_dec_sel;
   logic             r_msg_start;
   logic             r_msg_end;
   logic [5:0]       r_byte_idx;
   logic             r_unknown_type;
   logic             r_abort;
   logic [CNT_W-1:0] r_msg_count;

   logic [4:0]       w_type_sel;
   logic [5:0]       w_type_len;
   logic             w_known;
   logic [7:0]       w_gap_inc;
   logic             w_gap_hit;

   // Type byte decode; anything outside the five codes (including 0x00)
   // leaves the select empty and is treated as unknown.
   always_comb begin
      w_type_sel = 5'b00000;
      w_type_len = 6'd0;
      case (bus.byte_in)
         c_TYPE_A: begin w_type_sel = 5'b00001; w_type_len = c_LEN_A; end
         c_TYPE_X: begin w_type_sel = 5'b00010; w_type_len = c_LEN_X; end
         c_TYPE_D: begin w_type_sel = 5'b00100; w_type_len = c_LEN_D; end
         c_TYPE_U: begin w_type_sel = 5'b01000; w_type_len = c_LEN_U; end
         c_TYPE_E: begin w_type_sel = 5'b10000; w_type_len = c_LEN_E; end
         default:  begin w_type_sel = 5'b00000; w_type_len = 6'd0;    end
      endcase
   end

   assign w_known   = |w_type_sel;
   // Saturating increment; the threshold is judged on the incremented value
   // so a byte arriving on the would-be threshold cycle still wins.
   assign w_gap_inc = (r_gap_cnt == 8'hFF) ? 8'hFF : (r_gap_cnt + 8'd1);
   assign w_gap_hit = (w_gap_inc == c_GAP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_remaining    <= 6'd0;
         r_gap_cnt      <= 8'd0;
         r_cur_sel      <= 5'b00000;
         r_byte_out     <= 8'h00;
         r_valid_out    <= 1'b0;
         r_dec_sel      <= 5'b00000;
         r_msg_start    <= 1'b0;
         r_msg_end      <= 1'b0;
         r_byte_idx     <= 6'd0;
         r_unknown_type <= 1'b0;
         r_abort        <= 1'b0;
         r_msg_count    <= '0;
      end else begin
         // Strobes default low; byte_out/byte_idx hold when nothing is emitted.
         r_valid_out    <= 1'b0;
         r_msg_start    <= 1'b0;
         r_msg_end      <= 1'b0;
         r_unknown_type <= 1'b0;
         r_abort        <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_gap_cnt <= 8'd0;
               r_dec_sel <= 5'b00000;
               if (bus.valid_in) begin
                  if (w_known) begin
                     r_cur_sel   <= w_type_sel;
                     r_remaining <= w_type_len - 6'd1;
                     r_byte_out  <= bus.byte_in;
                     r_valid_out <= 1'b1;
                     r_dec_sel   <= w_type_sel;
                     r_msg_start <= 1'b1;
                     r_byte_idx  <= 6'd0;
                     r_state     <= S_ROUTE;
                  end else begin
                     r_unknown_type <= 1'b1;
                     r_state        <= S_DISCARD;
                  end
               end
            end

            S_ROUTE: begin
               if (bus.valid_in) begin
                  r_byte_out  <= bus.byte_in;
                  r_valid_out <= 1'b1;
                  r_dec_sel   <= r_cur_sel;
                  r_byte_idx  <= r_byte_idx + 6'd1;
                  r_remaining <= r_remaining - 6'd1;
                  r_gap_cnt   <= 8'd0;
                  if (r_remaining == 6'd1) begin
                     // Last byte: the select still rides along with it, the
                     // FSM is back in IDLE in time to take the next type byte.
                     r_msg_end   <= 1'b1;
                     r_msg_count <= r_msg_count + c_CNT_ONE;
                     r_cur_sel   <= 5'b00000;
                     r_state     <= S_IDLE;
                  end
               end else if (w_gap_hit) begin
                  r_abort   <= 1'b1;
                  r_cur_sel <= 5'b00000;
                  r_dec_sel <= 5'b00000;
                  r_gap_cnt <= 8'd0;
                  r_state   <= S_IDLE;
               end else begin
                  // Stall: keep the decoder selected across the gap.
                  r_dec_sel <= r_cur_sel;
                  r_gap_cnt <= w_gap_inc;
               end
            end

            S_DISCARD: begin
               r_dec_sel <= 5'b00000;
               if (bus.valid_in) begin
                  r_gap_cnt <= 8'd0;
               end else if (w_gap_hit) begin
                  r_gap_cnt <= 8'd0;
                  r_state   <= S_IDLE;
               end else begin
                  r_gap_cnt <= w_gap_inc;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_cur_sel <= 5'b00000;
               r_dec_sel <= 5'b00000;
               r_gap_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign bus.byte_out     = r_byte_out;
   assign bus.valid_out    = r_valid_out;
   assign bus.dec_sel      = r_dec_sel;
   assign bus.msg_start    = r_msg_start;
   assign bus.msg_end      = r_msg_end;
   assign bus.byte_idx     = r_byte_idx;
   assign bus.unknown_type = r_unknown_type;
   assign bus.abort        = r_abort;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.msg_count    = r_msg_count;

endmodule
`default_nettype wire

// File: tb/tb_itch_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_itch_msg_sequencer
//  Purpose  : Self-checking bench for itch_msg_sequencer. Stimulus pushes the
//             expected decoder-bus beat for every routed byte into a queue;
//             a negedge monitor pops and compares on every valid_out and
//             checks the held select on every other cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_itch_msg_sequencer;

   localparam int CNT_W = 4;
   localparam int GAP   = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   itch_msg_sequencer_if #(.CNT_W(CNT_W)) bus ();

   itch_msg_sequencer #(
      .GAP_TIMEOUT (GAP),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [7:0]       b;
      logic [5:0]       idx;
      logic [4:0]       sel;
      logic             st;
      logic             en;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks   = 0;
   int         n_fail     = 0;
   int         unk_seen   = 0;
   int         abort_seen = 0;
   int         model_cnt  = 0;
   logic [4:0] hold_sel   = 5'b00000;
   exp_t       mon_e;
   logic [4:0] mon_sel;

   function automatic logic [4:0] sel_of(input logic [7:0] t);
      case (t)
         8'h41:   return 5'b00001;
         8'h58:   return 5'b00010;
         8'h44:   return 5'b00100;
         8'h55:   return 5'b01000;
         8'h45:   return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Monitor / scoreboard consumer
   always @(negedge clk) begin
      if (!rst) begin
         hold_sel = 5'b00000;
      end else begin
         if (bus.unknown_type) unk_seen++;
         if (bus.abort)        abort_seen++;
         if (bus.valid_out) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat got byte=%h idx=%0d sel=%b want no beat",
                        bus.byte_out, bus.byte_idx, bus.dec_sel);
            end else begin
               mon_e = sb_q.pop_front();
               if ({bus.byte_out, bus.byte_idx, bus.dec_sel, bus.msg_start, bus.msg_end} !==
                   {mon_e.b, mon_e.idx, mon_e.sel, mon_e.st, mon_e.en} ||
                   (mon_e.en && bus.msg_count !== mon_e.cnt)) begin
                  n_fail++;
                  $display("FAIL beat got b=%h i=%0d s=%b st=%b en=%b cnt=%0d want b=%h i=%0d s=%b st=%b en=%b cnt=%0d",
                           bus.byte_out, bus.byte_idx, bus.dec_sel, bus.msg_start, bus.msg_end,
                           bus.msg_count, mon_e.b, mon_e.idx, mon_e.sel, mon_e.st, mon_e.en, mon_e.cnt);
               end
               hold_sel = mon_e.en ? 5'b00000 : mon_e.sel;
            end
         end else begin
            mon_sel = bus.abort ? 5'b00000 : hold_sel;
            n_checks++;
            if (bus.dec_sel !== mon_sel || bus.msg_start !== 1'b0 || bus.msg_end !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_sel got sel=%b st=%b en=%b want sel=%b st=0 en=0",
                        bus.dec_sel, bus.msg_start, bus.msg_end, mon_sel);
            end
            if (bus.abort) hold_sel = 5'b00000;
         end
      end
   end

   task automatic drive(input logic [7:0] b, input logic v);
      bus.byte_in  = b;
      bus.valid_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(8'h00, 1'b0);
   endtask

   // Sends nbytes of a message of total length len; optional stall of
   // gap_len cycles after byte indices gap_a and gap_b.
   task automatic send_msg(input logic [7:0] t, input int len, input int nbytes,
                           input int gap_a, input int gap_b, input int gap_len);
      logic [4:0] sel;
      logic [7:0] b;
      exp_t       e;
      sel = sel_of(t);
      for (int i = 0; i < nbytes; i++) begin
         b     = (i == 0) ? t : 8'(i * 3 + 16);
         e.b   = b;
         e.idx = 6'(i);
         e.sel = sel;
         e.st  = (i == 0);
         e.en  = (i == len - 1);
         if (e.en) model_cnt = (model_cnt + 1) % (1 << CNT_W);
         e.cnt = CNT_W'(model_cnt);
         sb_q.push_back(e);
         drive(b, 1'b1);
         if (i == gap_a || i == gap_b) repeat (gap_len) drive(8'hEE, 1'b0);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.byte_out, bus.valid_out, bus.dec_sel, bus.msg_start, bus.msg_end,
                  bus.byte_idx, bus.unknown_type, bus.abort, bus.busy, bus.msg_count});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   int a0, u0;

   initial begin
      bus.byte_in  = 8'h00;
      bus.valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", all_outs(), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Back-to-back A then D
      send_msg(8'h41, 36, 36, -1, -1, 0);
      send_msg(8'h44, 19, 19, -1, -1, 0);
      idle(3);
      check("b2b_count", 64'(bus.msg_count), 64'd2);
      check("b2b_idle_busy", 64'(bus.busy), 64'd0);

      // Stalls within X
      a0 = abort_seen;
      send_msg(8'h58, 23, 23, 5, 12, 3);
      idle(3);
      check("stall_count", 64'(bus.msg_count), 64'd3);
      check("stall_no_abort", 64'(abort_seen - a0), 64'd0);

      // Timeout: partial U, 16 idle, then E
      a0 = abort_seen;
      send_msg(8'h55, 35, 10, -1, -1, 0);
      idle(GAP);
      send_msg(8'h45, 31, 31, -1, -1, 0);
      idle(3);
      check("timeout_abort_pulses", 64'(abort_seen - a0), 64'd1);
      check("timeout_count", 64'(bus.msg_count), 64'd4);

      // Unknown type followed by junk that includes valid type codes
      u0 = unk_seen;
      a0 = abort_seen;
      drive(8'h5A, 1'b1);
      for (int i = 0; i < 20; i++) drive(8'(8'h41 + i), 1'b1);
      check("discard_busy", 64'(bus.busy), 64'd1);
      idle(GAP);
      send_msg(8'h41, 36, 36, -1, -1, 0);
      idle(3);
      check("unknown_pulses", 64'(unk_seen - u0), 64'd1);
      check("unknown_no_abort", 64'(abort_seen - a0), 64'd0);
      check("unknown_count", 64'(bus.msg_count), 64'd5);

      // Reset in the middle of an A message
      a0 = abort_seen;
      send_msg(8'h41, 36, 15, -1, -1, 0);
      @(negedge clk); #1;
      rst          = 1'b0;
      bus.valid_in = 1'b0;
      #1;
      check("reset_async", all_outs(), 64'd0);
      model_cnt = 0;
      @(posedge clk); #1;
      check("reset_held", all_outs(), 64'd0);
      @(negedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      send_msg(8'h44, 19, 19, -1, -1, 0);
      idle(3);
      check("reset_no_abort", 64'(abort_seen - a0), 64'd0);
      check("reset_then_d_count", 64'(bus.msg_count), 64'd1);

      // Counter wrap: 17 D messages from zero with a 4-bit counter
      rst = 1'b0;
      model_cnt = 0;
      @(negedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      for (int m = 0; m < 17; m++) send_msg(8'h44, 19, 19, -1, -1, 0);
      idle(3);
      check("wrap_count", 64'(bus.msg_count), 64'd1);

      idle(2);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
